// File: rtl/vpu_inst_issue_if.sv
// VPU issue-stage bus: host push channel plus VPU issue/done channel.
// The issue stage is the slave; the host/VPU side is the master.
interface vpu_inst_issue_if #(
    parameter int INST_W = 32
);
    logic              push_valid;
    logic [INST_W-1:0] push_inst;
    logic              push_ready;
    logic [INST_W-1:0] issue_inst;
    logic              issue_rdy;
    logic              mem_read_en;
    logic              mem_write_en;
    logic              vpu_done;

    modport slave (
        input  push_valid, push_inst, vpu_done,
        output push_ready, issue_inst, issue_rdy,
        output mem_read_en, mem_write_en
    );

    modport master (
        output push_valid, push_inst, vpu_done,
        input  push_ready, issue_inst, issue_rdy,
        input  mem_read_en, mem_write_en
    );
endinterface

// File: rtl/vpu_inst_issue.sv
// VPU instruction issue stage: FIFO buffer, opcode screen, strobe/done
// handshake with a completion watchdog, retired counter and drain pulse.
module vpu_inst_issue #(
    parameter int DEPTH   = 8,
    parameter int INST_W  = 32,
    parameter int OP_W    = 4,
    parameter int OP_MAX  = 7,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vpu_inst_issue_if.slave        bus,
    input  logic                   start,
    input  logic                   clear,
    output logic                   busy,
    output logic                   drain_done,
    output logic                   err_opcode,
    output logic                   timeout,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic [CNT_W-1:0]       retired_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int QW   = AW + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_e;

    state_e            state_q;
    logic [INST_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     wr_q;
    logic [QW-1:0]     cnt_q;
    logic              run_q;
    logic              rdy_q;
    logic              men_q;
    logic              drain_q;
    logic              err_q;
    logic              to_q;
    logic [INST_W-1:0] inst_q;
    logic [WD_W-1:0]   wd_q;
    logic [CNT_W-1:0]  ret_q;

    logic              push;
    logic              pop;
    logic              illegal;
    logic [INST_W-1:0] head;

    assign head           = mem_q[rd_q];
    assign bus.push_ready = cnt_q < QW'(DEPTH);
    assign push           = bus.push_valid && bus.push_ready && !clear;
    assign pop            = (state_q == S_LOAD) && !clear;
    assign illegal        = head[OP_W-1:0] > OP_W'(OP_MAX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= bus.push_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            rdy_q   <= 1'b0;
            men_q   <= 1'b0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            inst_q  <= '0;
            wd_q    <= '0;
            ret_q   <= '0;
        end else if (clear) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            rdy_q   <= 1'b0;
            men_q   <= 1'b0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            drain_q <= 1'b0;
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (start) begin
                run_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (run_q && cnt_q == '0) begin
                        run_q   <= 1'b0;
                        drain_q <= 1'b1;
                    end else if (run_q) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    inst_q <= head;
                    if (illegal) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        rdy_q   <= 1'b1;
                        men_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rdy_q   <= 1'b0;
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                // wd_q starts at 0 in the first WAIT cycle, so expiry
                // lands on the TIMEOUT-th edge after the strobe.
                S_WAIT: begin
                    if (bus.vpu_done) begin
                        ret_q   <= ret_q + 1'b1;
                        men_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wd_q == WD_W'(TIMEOUT - 2)) begin
                        to_q    <= 1'b1;
                        men_q   <= 1'b0;
                        state_q <= S_HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_inst   = inst_q;
    assign bus.issue_rdy    = rdy_q;
    assign bus.mem_read_en  = men_q;
    assign bus.mem_write_en = men_q;
    assign busy             = (state_q != S_IDLE) || run_q;
    assign drain_done       = drain_q;
    assign err_opcode       = err_q;
    assign timeout          = to_q;
    assign queue_count      = cnt_q;
    assign retired_cnt      = ret_q;
endmodule

// File: tb/tb_vpu_inst_issue.sv
// Scoreboard bench for vpu_inst_issue: expected instructions are queued
// at push time and popped on every issue strobe.
module tb_vpu_inst_issue;
    localparam int DEPTH   = 8;
    localparam int INST_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int LAT     = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   clear = 1'b0;
    logic                   busy;
    logic                   drain_done;
    logic                   err_opcode;
    logic                   timeout;
    logic [$clog2(DEPTH):0] queue_count;
    logic [CNT_W-1:0]       retired_cnt;

    vpu_inst_issue_if #(.INST_W(INST_W)) bus ();

    vpu_inst_issue #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .OP_W   (4),
        .OP_MAX (7),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .start      (start),
        .clear      (clear),
        .busy       (busy),
        .drain_done (drain_done),
        .err_opcode (err_opcode),
        .timeout    (timeout),
        .queue_count(queue_count),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          n_issue = 0;
    int          n_drain = 0;
    int          iss_cyc = 0;
    int          to_cyc = 0;
    int          force_cyc = -1;
    int          cd = 0;
    int          exp_ret = 0;
    bit          vpu_auto = 1'b1;
    bit          prev_rdy = 1'b0;
    bit          prev_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // VPU model and issue monitor
    initial begin
        bus.vpu_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.vpu_done = 1'b0;
            if (!rst_n) begin
                cd       = 0;
                prev_rdy = 1'b0;
                prev_to  = 1'b0;
            end else begin
                if (bus.issue_rdy) begin
                    chk("rdy_gap", 32'(prev_rdy), 0);
                    chk("mem_en", {bus.mem_read_en, bus.mem_write_en}, 3);
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("inst", bus.issue_inst, exp_q.pop_front());
                    end
                    n_issue++;
                    iss_cyc = cyc;
                    if (vpu_auto) cd = LAT;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.vpu_done = 1'b1;
                end
                if (cyc == force_cyc) bus.vpu_done = 1'b1;
                if (drain_done) n_drain++;
                if (timeout && !prev_to) to_cyc = cyc;
                prev_rdy = bus.issue_rdy;
                prev_to  = timeout;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] inst, input bit acc);
        bus.push_valid = 1'b1;
        bus.push_inst  = inst;
        step(1);
        bus.push_valid = 1'b0;
        if (acc && inst[3:0] <= 4'd7) exp_q.push_back(inst);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, 32'(busy), 0);
        step(2);
    endtask

    task automatic wait_issue(input string tag, input int i0, input int lim);
        int n = 0;
        while (n_issue == i0 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n_issue != i0), 1);
        step(1);
    endtask

    task automatic chk_rst();
        chk("rst_ready", 32'(bus.push_ready), 1);
        chk("rst_qcnt", 32'(queue_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'(bus.issue_rdy), 0);
        chk("rst_inst", bus.issue_inst, 0);
        chk("rst_men", {bus.mem_read_en, bus.mem_write_en}, 0);
        chk("rst_flags", {drain_done, err_opcode, timeout}, 0);
        chk("rst_ret", 32'(retired_cnt), 0);
    endtask

    initial begin
        int i0;
        int d0;
        int n;
        bus.push_valid = 1'b0;
        bus.push_inst  = '0;
        step(2);
        chk_rst();
        rst_n = 1'b1;
        step(1);

        // three legal instructions, auto-done VPU
        push_one(32'hA000_0010, 1);
        push_one(32'hB000_0021, 1);
        push_one(32'hC000_0032, 1);
        chk("qcnt3", 32'(queue_count), 3);
        i0 = n_issue;
        d0 = n_drain;
        pulse_start();
        wait_idle("drain1", 200);
        exp_ret += 3;
        chk("issues1", n_issue - i0, 3);
        chk("ret1", 32'(retired_cnt), exp_ret);
        chk("drain1_cnt", n_drain - d0, 1);
        chk("sb1", exp_q.size(), 0);

        // fill, overfill, push refused during first LOAD
        for (int k = 0; k < DEPTH; k++) begin
            push_one(32'h1000_0000 + (k << 8) + k, 1);
        end
        chk("full_rdy", 32'(bus.push_ready), 0);
        chk("qcnt8", 32'(queue_count), 8);
        push_one(32'hDEAD_0003, 0);
        chk("qcnt8b", 32'(queue_count), 8);
        i0 = n_issue;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        bus.push_valid = 1'b1;
        bus.push_inst  = 32'h2222_0004;
        step(1);
        chk("load_refuse", 32'(queue_count), 7);
        step(1);
        bus.push_valid = 1'b0;
        exp_q.push_back(32'h2222_0004);
        chk("issue_accept", 32'(queue_count), 8);
        wait_idle("drain2", 400);
        exp_ret += 9;
        chk("issues2", n_issue - i0, 9);
        chk("ret2", 32'(retired_cnt), exp_ret);
        chk("sb2", exp_q.size(), 0);

        // illegal opcode dropped
        push_one(32'h0000_0109, 1);
        push_one(32'h0000_0051, 1);
        i0 = n_issue;
        pulse_start();
        wait_idle("drain3", 200);
        exp_ret += 1;
        chk("err_set", 32'(err_opcode), 1);
        chk("issues3", n_issue - i0, 1);
        chk("ret3", 32'(retired_cnt), exp_ret);
        pulse_clear();
        chk("err_clr", 32'(err_opcode), 0);

        // watchdog expiry then clear
        vpu_auto = 1'b0;
        push_one(32'h0000_0A02, 1);
        i0 = n_issue;
        pulse_start();
        wait_issue("iss4", i0, 50);
        n = 0;
        while (!timeout && n < 200) begin
            step(1);
            n++;
        end
        chk("to_set", 32'(timeout), 1);
        step(1);
        chk("to_lat", to_cyc - iss_cyc, TIMEOUT);
        chk("halt_busy", 32'(busy), 1);
        chk("halt_men", {bus.mem_read_en, bus.mem_write_en}, 0);
        push_one(32'h0000_0B03, 1);
        chk("halt_push", 32'(queue_count), 1);
        step(10);
        chk("halt_noiss", n_issue - i0, 1);
        pulse_clear();
        exp_q.delete();
        chk("clr_to", 32'(timeout), 0);
        chk("clr_qcnt", 32'(queue_count), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("ret4", 32'(retired_cnt), exp_ret);

        // done on the expiry cycle wins
        push_one(32'h0000_0C04, 1);
        i0 = n_issue;
        pulse_start();
        wait_issue("iss5", i0, 50);
        force_cyc = iss_cyc + TIMEOUT - 1;
        wait_idle("drain5", 200);
        force_cyc = -1;
        exp_ret += 1;
        chk("to_race", 32'(timeout), 0);
        chk("ret5", 32'(retired_cnt), exp_ret);

        // async reset during WAIT with 4 queued
        for (int k = 0; k < 5; k++) begin
            push_one(32'h3000_0000 + (k << 4) + k, 1);
        end
        i0 = n_issue;
        pulse_start();
        wait_issue("iss6", i0, 50);
        step(2);
        chk("wait_q4", 32'(queue_count), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst();
        step(1);
        exp_q.delete();
        rst_n = 1'b1;
        i0 = n_issue;
        step(20);
        chk("post_rst_noiss", n_issue - i0, 0);
        chk("post_rst_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
